// File: rtl/masked_adder_arbiter_pkg.sv
// Shared constants, tag type and masked-share helpers for the masked adder arbiter.
package masked_adder_arbiter_pkg;

  localparam int D       = 2;
  localparam int N       = 4;
  localparam int ADD_LAT = 4;

  function automatic int rnd_width(input int d);
    return 4 * d * (d - 1) / 2;
  endfunction

  localparam int RND_W   = rnd_width(D);
  localparam int NPAIR   = D * (D - 1) / 2;
  localparam int IDX_W   = $clog2(N);
  localparam int SHARE_W = 2 * D;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [SHARE_W-1:0] share_slice(input logic [N*SHARE_W-1:0] bus,
                                                     input logic [IDX_W-1:0]     i);
    return bus[i*SHARE_W +: SHARE_W];
  endfunction

  // DOM cross products; the (i,j) and (j,i) terms share one random bit so they cancel.
  function automatic logic [D*D-1:0] dom_cross(input logic [D-1:0]     x,
                                               input logic [D-1:0]     y,
                                               input logic [NPAIR-1:0] r);
    logic [D*D-1:0] t;
    int lo;
    int hi;
    t  = '0;
    lo = 0;
    hi = 0;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        t[i*D+j] = x[i] & y[j];
        if (i != j) begin
          lo = (i < j) ? i : j;
          hi = (i < j) ? j : i;
          t[i*D+j] = t[i*D+j] ^ r[lo*D - lo*(lo+1)/2 + hi - lo - 1];
        end
      end
    end
    return t;
  endfunction

  function automatic logic [D-1:0] dom_compress(input logic [D*D-1:0] t);
    logic [D-1:0] z;
    for (int i = 0; i < D; i++) begin
      z[i] = ^t[i*D +: D];
    end
    return z;
  endfunction

endpackage

// File: rtl/adder_2bit.sv
// Pipelined masked 2-bit adder: a in cycle t, b in t+1, out_c settles in t+ADD_LAT-1;
// the consumer's response register forms the last stage of the ADD_LAT latency.
module adder_2bit
  import masked_adder_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [SHARE_W-1:0] a,
  input  logic [SHARE_W-1:0] b,
  input  logic [RND_W-1:0]   rnd,
  output logic [3*D-1:0]     out_c
);

  logic [SHARE_W-1:0]   a_r;
  logic [RND_W-1:0]     rnd_r;
  logic [D*D-1:0]       g0_t_r;
  logic [D*D-1:0]       g1_t_r;
  logic [D-1:0]         s0_1_r;
  logic [D-1:0]         p1_r;
  logic [D-1:0]         a1_r;
  logic [D-1:0]         b1_r;
  logic [2*NPAIR-1:0]   rnd_1_r;
  logic [D*D-1:0]       ag_t_r;
  logic [D*D-1:0]       bg_t_r;
  logic [D-1:0]         g1_r;
  logic [D-1:0]         s0_2_r;
  logic [D-1:0]         s1_r;
  logic [D-1:0]         g0_s;

  assign g0_s = dom_compress(g0_t_r);

  // carry = maj(a1, b1, g0) = a1&b1 ^ a1&g0 ^ b1&g0, one DOM gadget per product
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      rnd_r   <= '0;
      g0_t_r  <= '0;
      g1_t_r  <= '0;
      s0_1_r  <= '0;
      p1_r    <= '0;
      a1_r    <= '0;
      b1_r    <= '0;
      rnd_1_r <= '0;
      ag_t_r  <= '0;
      bg_t_r  <= '0;
      g1_r    <= '0;
      s0_2_r  <= '0;
      s1_r    <= '0;
    end else begin
      a_r     <= a;
      rnd_r   <= rnd;
      g0_t_r  <= dom_cross(a_r[D-1:0], b[D-1:0], rnd_r[0 +: NPAIR]);
      g1_t_r  <= dom_cross(a_r[2*D-1:D], b[2*D-1:D], rnd_r[NPAIR +: NPAIR]);
      s0_1_r  <= a_r[D-1:0] ^ b[D-1:0];
      p1_r    <= a_r[2*D-1:D] ^ b[2*D-1:D];
      a1_r    <= a_r[2*D-1:D];
      b1_r    <= b[2*D-1:D];
      rnd_1_r <= rnd_r[2*NPAIR +: 2*NPAIR];
      ag_t_r  <= dom_cross(a1_r, g0_s, rnd_1_r[0 +: NPAIR]);
      bg_t_r  <= dom_cross(b1_r, g0_s, rnd_1_r[NPAIR +: NPAIR]);
      g1_r    <= dom_compress(g1_t_r);
      s0_2_r  <= s0_1_r;
      s1_r    <= p1_r ^ g0_s;
    end
  end

  assign out_c = {g1_r ^ dom_compress(ag_t_r) ^ dom_compress(bg_t_r), s1_r, s0_2_r};

endmodule

// File: rtl/masked_adder_arbiter_rr.sv
// Round-robin grant over N requesters with a registered rotation pointer.
module rr_arbiter_n #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 issue
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] pick_s;
  logic [IW-1:0] cand_s;
  logic          found_s;
  int            c;

  // first requesting index at or above the pointer, wrapping past N-1
  always_comb begin
    pick_s  = ptr_r;
    found_s = 1'b0;
    cand_s  = ptr_r;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_r) + k;
      if (c >= N) begin
        c = c - N;
      end else begin
        c = c;
      end
      cand_s = IW'(c);
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign issue     = found_s & en & ~rst;
  assign grant     = issue ? (N'(1'b1) << pick_s) : {N{1'b0}};
  assign grant_idx = pick_s;

  // pointer moves just past the winner, holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (issue) begin
      ptr_r <= (pick_s == IW'(N - 1)) ? IW'(0) : pick_s + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/masked_adder_arbiter.sv
// Shares one masked 2-bit adder among N requesters: round-robin issue gated on fresh
// randomness, b operand skewed one cycle, tags tracked to route results back.
module masked_adder_arbiter
  import masked_adder_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*SHARE_W-1:0] req_a,
  input  logic [N*SHARE_W-1:0] req_b,
  input  logic [RND_W-1:0]     rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [N-1:0]         resp_valid,
  output logic [3*D-1:0]       resp_c,
  output logic                 busy
);

  logic [N-1:0]       grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               issue_s;
  logic [SHARE_W-1:0] add_a_s;
  logic [RND_W-1:0]   add_rnd_s;
  logic [3*D-1:0]     out_c_s;
  logic [SHARE_W-1:0] b_skew_r;
  logic               skew_valid_r;
  tag_t               tag_r [ADD_LAT];
  logic [N-1:0]       resp_valid_r;
  logic [3*D-1:0]     resp_c_r;
  logic               busy_s;

  rr_arbiter_n #(.N(N)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (rnd_valid),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .issue     (issue_s)
  );

  // idle cycles feed the all-zero share encoding so no requester data leaks in
  always_comb begin
    add_a_s   = '0;
    add_rnd_s = '0;
    if (issue_s) begin
      add_a_s   = share_slice(req_a, grant_idx_s);
      add_rnd_s = rnd_in;
    end else begin
      add_a_s   = '0;
      add_rnd_s = '0;
    end
  end

  adder_2bit u_add (
    .clk   (clk),
    .rst   (rst),
    .a     (add_a_s),
    .b     (b_skew_r),
    .rnd   (add_rnd_s),
    .out_c (out_c_s)
  );

  // b skew, tag shift register and response capture aligned with out_c
  always_ff @(posedge clk) begin
    if (rst) begin
      b_skew_r     <= '0;
      skew_valid_r <= 1'b0;
      for (int k = 0; k < ADD_LAT; k++) begin
        tag_r[k] <= '0;
      end
      resp_valid_r <= '0;
      resp_c_r     <= '0;
    end else begin
      b_skew_r     <= issue_s ? share_slice(req_b, grant_idx_s) : {SHARE_W{1'b0}};
      skew_valid_r <= issue_s;
      tag_r[0]     <= '{valid: issue_s, idx: grant_idx_s};
      for (int k = 1; k < ADD_LAT; k++) begin
        tag_r[k] <= tag_r[k-1];
      end
      resp_valid_r <= tag_r[ADD_LAT-2].valid ? (N'(1'b1) << tag_r[ADD_LAT-2].idx) : {N{1'b0}};
      resp_c_r     <= tag_r[ADD_LAT-2].valid ? out_c_s : resp_c_r;
    end
  end

  always_comb begin
    busy_s = skew_valid_r;
    for (int k = 0; k < ADD_LAT; k++) begin
      busy_s = busy_s | tag_r[k].valid;
    end
  end

  assign req_ready  = grant_s;
  assign rnd_ready  = issue_s;
  assign resp_valid = resp_valid_r;
  assign resp_c     = resp_c_r;
  assign busy       = busy_s;

endmodule
